// File: rtl/ifft_pkg.sv
// Shared IFFT types, widths and the Q8.8 saturation helper.
// Contents: DATA_W, TW_FRAC, PROD_W, SUM_W, SAT_MAX/SAT_MIN, cplx_t, sat_q88().
package ifft_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TW_FRAC = 8;
  localparam int unsigned PROD_W  = 2 * DATA_W;
  localparam int unsigned SUM_W   = PROD_W + 1;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Clamp a scaled sum into the signed DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat_q88(input logic signed [SUM_W-1:0] x);
    logic signed [DATA_W-1:0] r;
    if (x > SUM_W'(SAT_MAX)) begin
      r = SAT_MAX;
    end else if (x < SUM_W'(SAT_MIN)) begin
      r = SAT_MIN;
    end else begin
      r = DATA_W'(x);
    end
    return r;
  endfunction

endpackage

// File: rtl/ifft_cmul_q88.sv
// Two-stage Q8.8 complex multiply pipeline: E1 registers the four partial
// products, E2 registers the scaled and saturated result.
// Config macro: IFFT_TW_ROUND_EN selects round-half-up instead of truncation.
// Ports: clk, rst_n, en (pipeline advance), in_valid/in_sop/a/w (stage-1 data),
//        out_valid/out_sop/prod (registered result).
module ifft_cmul_q88
  import ifft_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  in_valid,
  input  logic  in_sop,
  input  cplx_t a,
  input  cplx_t w,
  output logic  out_valid,
  output logic  out_sop,
  output cplx_t prod
);

`ifdef IFFT_TW_ROUND_EN
  localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(2 ** (TW_FRAC - 1));
`endif

  logic                     s2_valid;
  logic                     s2_sop;
  logic signed [PROD_W-1:0] pr_rr;
  logic signed [PROD_W-1:0] pr_ii;
  logic signed [PROD_W-1:0] pr_ri;
  logic signed [PROD_W-1:0] pr_ir;
  logic signed [SUM_W-1:0]  sum_re;
  logic signed [SUM_W-1:0]  sum_im;
  cplx_t                    res;

  // E1: partial products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sop   <= 1'b0;
      pr_rr    <= '0;
      pr_ii    <= '0;
      pr_ri    <= '0;
      pr_ir    <= '0;
    end else if (en) begin
      s2_valid <= in_valid;
      s2_sop   <= in_sop;
      pr_rr    <= PROD_W'(a.re) * PROD_W'(w.re);
      pr_ii    <= PROD_W'(a.im) * PROD_W'(w.im);
      pr_ri    <= PROD_W'(a.re) * PROD_W'(w.im);
      pr_ir    <= PROD_W'(a.im) * PROD_W'(w.re);
    end
  end

  // Sum, optional rounding, arithmetic rescale, saturate
  always_comb begin
    sum_re = SUM_W'(pr_rr) - SUM_W'(pr_ii);
    sum_im = SUM_W'(pr_ri) + SUM_W'(pr_ir);
`ifdef IFFT_TW_ROUND_EN
    sum_re = sum_re + RND_HALF;
    sum_im = sum_im + RND_HALF;
`endif
    res.re = sat_q88(sum_re >>> TW_FRAC);
    res.im = sat_q88(sum_im >>> TW_FRAC);
  end

  // E2: output register; data only moves with a valid sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      prod      <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sop <= s2_sop;
        prod    <= res;
      end
    end
  end

endmodule

// File: rtl/ifft_twiddle_cmul_stage.sv
// IFFT stage twiddle multiplier: owns the twiddle ROM address counter, aligns
// each sample with the 1-cycle synchronous ROM read and returns a*W in Q8.8.
// Fixed 3-edge latency, one sample per cycle, valid/ready on both sides.
// Config macro: IFFT_TW_ROUND_EN (round half up before the >>>8 rescale).
// Ports: clk, rst_n; in_valid/in_ready/in_sop/in_re/in_im (sample in);
//        rom_addr -> twiddle ROMs, tw_re/tw_im <- ROM data;
//        out_valid/out_ready/out_sop/out_re/out_im (product out).
module ifft_twiddle_cmul_stage
  import ifft_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned N_TW   = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] tw_re,
  input  logic [DATA_W-1:0] tw_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im
);

  logic              stall;
  logic              accept;
  logic [ADDR_W-1:0] addr_sel;
  logic [ADDR_W-1:0] tw_nxt;
  logic [ADDR_W-1:0] tw_cnt;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_valid;
  logic              s1_sop;
  cplx_t             s1_samp;
  cplx_t             tw;
  cplx_t             prod;

  // Handshake and address select; during stall the ROMs re-read the held
  // sample's twiddle so their output stays aligned with s1.
  always_comb begin
    stall    = out_valid & ~out_ready;
    accept   = in_valid & ~stall;
    addr_sel = in_sop ? '0 : tw_cnt;
    tw_nxt   = (addr_sel == ADDR_W'(N_TW - 1)) ? '0 : addr_sel + ADDR_W'(1);
    rom_addr = stall ? s1_addr : addr_sel;
    tw       = cplx_t'{re: tw_re, im: tw_im};
  end

  assign in_ready = ~stall;

  // E0: sample capture alongside the ROM read, twiddle counter advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_cnt   <= '0;
      s1_addr  <= '0;
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_samp  <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_samp <= cplx_t'{re: in_re, im: in_im};
        s1_sop  <= in_sop;
        s1_addr <= addr_sel;
        tw_cnt  <= tw_nxt;
      end
    end
  end

  ifft_cmul_q88 u_cmul (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (~stall),
    .in_valid  (s1_valid),
    .in_sop    (s1_sop),
    .a         (s1_samp),
    .w         (tw),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .prod      (prod)
  );

  assign out_re = prod.re;
  assign out_im = prod.im;

endmodule
